// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-master / one-slave memory arbiter. The core's instruction (prefetch)
//   bus and its data (load/store) bus share one external memory port. A grant
//   is registered and held until the slave acks. There is always at least one
//   IDLE cycle between grants. Data requests win arbitration unless
//   DATA_BURST_MAX data grants have completed back to back while an
//   instruction request was waiting; in that case the instruction master wins.
//
//   Optional feature macro: MEM_ARBITER_STATS_EN
//     When defined, adds the 16-bit wrapping completion counters
//     instr_grant_count and data_grant_count.
//
//   Ports
//     clk, reset          system clock, synchronous active-high reset
//     instr_m_*           instruction master (read only)
//     data_m_*            data master (read/write, byte lanes)
//     q_m_*               external memory port
//     *_grant_count       completed grants per master (stats build only)
//
//   state       | meaning
//   ------------+-------------------------------------------------
//   IDLE        | no grant; arbitrate on the next rising edge
//   GRANT_INSTR | memory port driven by instruction master
//   GRANT_DATA  | memory port driven by data master
module mem_arbiter #(
  parameter int DATA_BURST_MAX = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] instr_m_addr,
  output logic [15:0] instr_m_data_in,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  input  logic [19:1] data_m_addr,
  output logic [15:0] data_m_data_in,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  output logic        data_m_ack,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  output logic [19:1] q_m_addr,
  input  logic [15:0] q_m_data_in,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  input  logic        q_m_ack,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [15:0] instr_grant_count,
  output logic [15:0] data_grant_count
`endif
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] GRANT_INSTR = 2'd1;
  localparam logic [1:0] GRANT_DATA  = 2'd2;

  localparam logic [2:0] BURST_MAX = 3'(DATA_BURST_MAX);

  logic [1:0] state;
  logic [2:0] burst_cnt;

  logic instr_done;
  logic data_done;

  assign instr_done = (state == GRANT_INSTR) && q_m_ack;
  assign data_done  = (state == GRANT_DATA) && q_m_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      burst_cnt <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (data_m_access && instr_m_access) begin
            // Data normally wins; the burst limit keeps fetches moving.
            state <= (burst_cnt == BURST_MAX) ? GRANT_INSTR : GRANT_DATA;
          end else if (data_m_access) begin
            state <= GRANT_DATA;
          end else if (instr_m_access) begin
            state <= GRANT_INSTR;
          end
        end
        GRANT_INSTR: begin
          if (q_m_ack) begin
            state     <= IDLE;
            burst_cnt <= 3'd0;
          end
        end
        GRANT_DATA: begin
          if (q_m_ack) begin
            state <= IDLE;
            // Only consecutive data grants that actually held off a waiting
            // fetch count toward the limit.
            if (instr_m_access) begin
              if (burst_cnt < BURST_MAX) begin
                burst_cnt <= burst_cnt + 3'd1;
              end
            end else begin
              burst_cnt <= 3'd0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The memory port is a pure function of the grant; master fields are not
  // latched, so masters must hold them stable for the whole access.
  always_comb begin
    q_m_access   = 1'b0;
    q_m_addr     = '0;
    q_m_data_out = '0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = 2'b00;
    case (state)
      GRANT_INSTR: begin
        q_m_access  = 1'b1;
        q_m_addr    = instr_m_addr;
        q_m_bytesel = 2'b11;
      end
      GRANT_DATA: begin
        q_m_access   = 1'b1;
        q_m_addr     = data_m_addr;
        q_m_data_out = data_m_data_out;
        q_m_wr_en    = data_m_wr_en;
        q_m_bytesel  = data_m_bytesel;
      end
      default: ;
    endcase
  end

  assign instr_m_ack     = instr_done;
  assign data_m_ack      = data_done;
  assign instr_m_data_in = q_m_data_in;
  assign data_m_data_in  = q_m_data_in;

`ifdef MEM_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_grant_count <= 16'd0;
      data_grant_count  <= 16'd0;
    end else begin
      if (instr_done) instr_grant_count <= instr_grant_count + 16'd1;
      if (data_done)  data_grant_count  <= data_grant_count + 16'd1;
    end
  end
`endif

endmodule
